cpu_top: RTL and testbench
==========================

# cpu_top

Single-cycle RV64I-subset processor core with machine-mode exception handling for illegal instructions, load/store access faults and instruction access faults. It is the top of the CPU hierarchy: it owns the PC, register file, a 512-byte instruction memory, a 512-byte data memory and the trap CSRs. Its only ports are clock and reset. Program loading and result checking use hierarchical access.

## Interface
- No parameters. Fixed sizes:
  - instruction memory 128 x 32 bits
  - data memory 512 bytes
  - 32 x 64-bit registers
- clk  input  1  system clock; all state updates on the rising edge.
- rstn  input  1  reset. One clock; reset is synchronous and active-high, so rstn=1 on a rising edge resets the core.
- Required internal hierarchy:
  - submodule instance `instruction_cache_mem` containing array `inst_mem_L1[0:127]` (32-bit). Word i holds the instruction at byte address 4i. Benches load it by hierarchical assignment.
  - register file array `rf[0:31]` (64-bit) at top level.
  - CSRs `mepc` and `mcause` (64-bit) at top level.

## Operation
- Each instruction completes in one cycle: fetch `inst_mem_L1[pc[8:2]]`, decode, execute, write back, then update pc.
- Supported instructions (standard RV64I encodings):
  - ADDI, ADD, SUB, AND, OR, XOR, ANDI, ORI, XORI, SLLI, SRLI, LUI
  - LW (sign-extended), LD, SW, SD
  - BEQ, BNE, JAL, JALR
  - MRET (0x30200073)
- Word 0x00000000 is a NOP: pc advances by 4 and there is no state change.
- x0 reads 0. Writes to x0 are discarded.
- Arithmetic is 64-bit, wrap-around. I-type immediates are 12-bit sign-extended.
- Illegal instruction: any other word, e.g. opcode 0x7F or unsupported funct3/funct7.
  - mcause=2, mepc=pc+4, pc←0x1E0 (480).
  - No register or memory write.
- Load/store access fault: effective address (rs1+imm) with addr+size>512.
  - mcause=5, mepc=pc+4, pc←0x1D8 (472).
  - No register or memory write.
- Instruction access fault: a taken JAL/JALR/branch whose target is ≥512.
  - mcause=1, mepc=pc+4, pc←0x1E8 (488).
  - The jump's rd is not written.
- A misaligned branch/jump target (bit1 or bit0 set) is also an instruction access fault.
- MRET: pc←mepc. No other state change. MRET with no prior trap jumps to mepc's current value.
- Only one exception per instruction. Priority: illegal > instruction access > load/store.
- Data memory is little-endian. It is not cleared by reset.
- Sequential pc wraps from 508 to 0 (9-bit address space).

## Timing
- Reset (rstn=1 at an edge):
  - pc=0, rf all 0, mepc=0, mcause=0.
  - Instruction memory and data memory are unchanged.
- rstn asserted mid-program forces the reset state on that edge. Execution restarts at 0 on the first edge with rstn=0.
- One instruction retires per clock edge with rstn=0.
- Trap entry takes one cycle: on the faulting instruction's edge, pc←handler and the CSRs update. The handler's first instruction executes on the next edge.
- MRET takes one cycle.
- Register writes are visible to the next instruction. There are no hazards.

## Test plan
- Arithmetic:
  - Program: addi x1,x1,2 then NOPs.
  - Hold rstn=1 for 2 edges, release, run 1 cycle: x1=2, pc=4.
- Illegal opcode:
  - Program: 0x00208093 (addi x1,x1,2), 0x0023037F, 0x10118193 (addi x3,x3,0x101).
  - Handler at 480: 0x00208393 (addi x7,x1,2), then mret 0x30200073.
  - Run 5 cycles: x1=2, x7=4, mcause=2, mepc=8, x3=257, pc=12.
- Load access fault:
  - lw 0x3E82A503 (lw x10,1000(x5)) at pc 20, with x5=0.
  - Handler at 472: 0x00108393 (addi x7,x1,1), then mret.
  - Required: x10 unchanged, x7=x1+1, mcause=5, mepc=24, execution resumes at 24.
- Instruction access fault:
  - 0x3E80006F (jal x0,1000) at pc 36.
  - Handler at 488: 0x00308393 (addi x7,x1,3), then mret.
  - Required: x7=5 with x1=2, mcause=1, mepc=40, resumes at 40.
- Full sequence (all of the above at addresses 0-52, addi x3/x4 0x101 repeated three times):
  - After 18 cycles: x3=771, x4=771, x7=5.
- Store/load round trip and reset:
  - sd x1,8(x0) then ld x2,8(x0) gives x2=x1.
  - Assert rstn mid-run: pc=0 and all rf=0 next cycle, and memory contents are preserved.

Source files
------------

// File: rtl/cpu_top.sv
// Single-cycle RV64I-subset core with machine-mode trap entry and MRET.
// Owns pc, register file, instruction/data memories and the mepc/mcause CSRs.

// Instruction store; the write port exists for loaders, the core ties it off.
module icache_mem (
  input  logic        clk,
  input  logic        wr_en_i,
  input  logic [6:0]  wr_addr_i,
  input  logic [31:0] wr_data_i,
  input  logic [6:0]  rd_addr_i,
  output logic [31:0] rd_data_o
);
  logic [31:0] inst_mem_L1 [0:127];

  // Optional word write from an external loader
  always_ff @(posedge clk) begin
    if (wr_en_i) inst_mem_L1[wr_addr_i] <= wr_data_i;
  end

  assign rd_data_o = inst_mem_L1[rd_addr_i];
endmodule

module cpu_top (
  input logic clk,
  input logic rstn
);
  typedef enum logic [1:0] {EXC_NONE, EXC_ILLEGAL, EXC_IACCESS, EXC_LSACCESS} exc_e;

  localparam logic [6:0]  OPC_LOAD   = 7'b0000011;
  localparam logic [6:0]  OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0]  OPC_STORE  = 7'b0100011;
  localparam logic [6:0]  OPC_OP     = 7'b0110011;
  localparam logic [6:0]  OPC_LUI    = 7'b0110111;
  localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
  localparam logic [6:0]  OPC_JALR   = 7'b1100111;
  localparam logic [6:0]  OPC_JAL    = 7'b1101111;
  localparam logic [31:0] INST_MRET  = 32'h30200073;

  logic [63:0] pc_q, pc_d;
  logic [63:0] rf [0:31];
  logic [63:0] mepc, mepc_d;
  logic [63:0] mcause, mcause_d;
  logic [7:0]  dmem [0:511];

  logic [31:0] inst;
  logic [6:0]  opcode, f7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic [63:0] imm_i, imm_s, imm_b, imm_j, imm_u;
  logic [63:0] rs1_val, rs2_val, ld_addr, st_addr, load_dw, link, pc_seq, target;
  logic        rf_we, dm_we, br_taken;
  logic [63:0] rf_wdata;
  logic [3:0]  ls_size;
  exc_e        exc;

  icache_mem instruction_cache_mem (
    .clk       (clk),
    .wr_en_i   (1'b0),
    .wr_addr_i ('0),
    .wr_data_i ('0),
    .rd_addr_i (pc_q[8:2]),
    .rd_data_o (inst)
  );

  assign opcode  = inst[6:0];
  assign rd      = inst[11:7];
  assign f3      = inst[14:12];
  assign rs1     = inst[19:15];
  assign rs2     = inst[24:20];
  assign f7      = inst[31:25];
  assign imm_i   = {{52{inst[31]}}, inst[31:20]};
  assign imm_s   = {{52{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b   = {{51{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_j   = {{43{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  assign imm_u   = {{32{inst[31]}}, inst[31:12], 12'h000};
  assign rs1_val = (rs1 == 5'd0) ? '0 : rf[rs1];
  assign rs2_val = (rs2 == 5'd0) ? '0 : rf[rs2];
  assign ld_addr = rs1_val + imm_i;
  assign st_addr = rs1_val + imm_s;
  assign link    = pc_q + 64'd4;
  assign pc_seq  = {55'd0, pc_q[8:0] + 9'd4};

  // Little-endian doubleword gathered at the load address (9-bit wrap)
  always_comb begin
    load_dw = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      load_dw[8*i +: 8] = dmem[ld_addr[8:0] + 9'(i)];
    end
  end

  // Decode/execute: next pc, writeback, store enable and trap selection
  always_comb begin
    pc_d     = pc_seq;
    mepc_d   = mepc;
    mcause_d = mcause;
    rf_we    = 1'b0;
    rf_wdata = '0;
    dm_we    = 1'b0;
    ls_size  = 4'd4;
    br_taken = 1'b0;
    target   = '0;
    exc      = EXC_NONE;
    case (opcode)
      7'b0000000: if (inst != '0) exc = EXC_ILLEGAL;
      OPC_OPIMM: begin
        rf_we = 1'b1;
        case (f3)
          3'b000: rf_wdata = rs1_val + imm_i;
          3'b100: rf_wdata = rs1_val ^ imm_i;
          3'b110: rf_wdata = rs1_val | imm_i;
          3'b111: rf_wdata = rs1_val & imm_i;
          3'b001: if (inst[31:26] == 6'd0) rf_wdata = rs1_val << inst[25:20];
                  else exc = EXC_ILLEGAL;
          3'b101: if (inst[31:26] == 6'd0) rf_wdata = rs1_val >> inst[25:20];
                  else exc = EXC_ILLEGAL;
          default: exc = EXC_ILLEGAL;
        endcase
      end
      OPC_OP: begin
        rf_we = 1'b1;
        if (f7 == 7'b0000000) begin
          case (f3)
            3'b000:  rf_wdata = rs1_val + rs2_val;
            3'b100:  rf_wdata = rs1_val ^ rs2_val;
            3'b110:  rf_wdata = rs1_val | rs2_val;
            3'b111:  rf_wdata = rs1_val & rs2_val;
            default: exc = EXC_ILLEGAL;
          endcase
        end else if (f7 == 7'b0100000 && f3 == 3'b000) begin
          rf_wdata = rs1_val - rs2_val;
        end else begin
          exc = EXC_ILLEGAL;
        end
      end
      OPC_LUI: begin
        rf_we    = 1'b1;
        rf_wdata = imm_u;
      end
      OPC_LOAD: begin
        if (f3 == 3'b010 || f3 == 3'b011) begin
          ls_size  = f3[0] ? 4'd8 : 4'd4;
          rf_we    = 1'b1;
          rf_wdata = f3[0] ? load_dw : {{32{load_dw[31]}}, load_dw[31:0]};
          // Compare against 512-size so huge addresses cannot wrap past the check
          if (ld_addr > 64'd512 - {60'd0, ls_size}) exc = EXC_LSACCESS;
        end else begin
          exc = EXC_ILLEGAL;
        end
      end
      OPC_STORE: begin
        if (f3 == 3'b010 || f3 == 3'b011) begin
          ls_size = f3[0] ? 4'd8 : 4'd4;
          dm_we   = 1'b1;
          if (st_addr > 64'd512 - {60'd0, ls_size}) exc = EXC_LSACCESS;
        end else begin
          exc = EXC_ILLEGAL;
        end
      end
      OPC_BRANCH: begin
        target = pc_q + imm_b;
        case (f3)
          3'b000:  br_taken = (rs1_val == rs2_val);
          3'b001:  br_taken = (rs1_val != rs2_val);
          default: exc = EXC_ILLEGAL;
        endcase
      end
      OPC_JAL: begin
        br_taken = 1'b1;
        target   = pc_q + imm_j;
        rf_we    = 1'b1;
        rf_wdata = link;
      end
      OPC_JALR: begin
        if (f3 == 3'b000) begin
          br_taken = 1'b1;
          target   = (rs1_val + imm_i) & ~64'd1;
          rf_we    = 1'b1;
          rf_wdata = link;
        end else begin
          exc = EXC_ILLEGAL;
        end
      end
      default: begin
        if (inst == INST_MRET) pc_d = mepc;
        else exc = EXC_ILLEGAL;
      end
    endcase

    // br_taken is only set for legally decoded control transfers
    if (br_taken) begin
      if (target >= 64'd512 || target[1:0] != 2'b00) exc = EXC_IACCESS;
      else pc_d = target;
    end

    if (exc != EXC_NONE) begin
      rf_we  = 1'b0;
      dm_we  = 1'b0;
      mepc_d = link;
      case (exc)
        EXC_ILLEGAL: begin mcause_d = 64'd2; pc_d = 64'd480; end
        EXC_IACCESS: begin mcause_d = 64'd1; pc_d = 64'd488; end
        default:     begin mcause_d = 64'd5; pc_d = 64'd472; end
      endcase
    end

    if (rd == 5'd0) rf_we = 1'b0;
  end

  // Architectural state: pc, CSRs and register file, synchronous reset
  always_ff @(posedge clk) begin
    if (rstn) begin
      pc_q   <= '0;
      mepc   <= '0;
      mcause <= '0;
      for (int unsigned i = 0; i < 32; i++) rf[i] <= '0;
    end else begin
      pc_q   <= pc_d;
      mepc   <= mepc_d;
      mcause <= mcause_d;
      if (rf_we) rf[rd] <= rf_wdata;
    end
  end

  // Data memory byte writes; contents survive reset, no store during reset
  always_ff @(posedge clk) begin
    if (dm_we && !rstn) begin
      for (int unsigned i = 0; i < 8; i++) begin
        if (i < 32'(ls_size)) dmem[st_addr[8:0] + 9'(i)] <= rs2_val[8*i +: 8];
      end
    end
  end
endmodule

// File: tb/tb_cpu_top.sv
// Directed bench for cpu_top: arithmetic, traps, memory round trip, reset.
module tb_cpu_top;
  logic clk  = 1'b0;
  logic rstn = 1'b1;
  int unsigned n_run  = 0;
  int unsigned n_fail = 0;

  always #5 clk = ~clk;

  cpu_top dut (
    .clk  (clk),
    .rstn (rstn)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic put(input int addr, input logic [31:0] word);
    dut.instruction_cache_mem.inst_mem_L1[addr / 4] = word;
  endtask

  task automatic clear_imem;
    for (int i = 0; i < 128; i++) dut.instruction_cache_mem.inst_mem_L1[i] = 32'h0;
  endtask

  function automatic logic [63:0] rf_nonzero();
    logic [63:0] c = '0;
    for (int i = 0; i < 32; i++) if (dut.rf[i] != 64'd0) c++;
    return c;
  endfunction

  initial begin
    // Program A: full trap sequence plus handlers
    clear_imem();
    put(0,  32'h00208093); put(4,  32'h0023037F); put(8,  32'h10118193);
    put(12, 32'h10120213); put(16, 32'h10118193); put(20, 32'h3E82A503);
    put(24, 32'h10120213); put(28, 32'h10118193); put(32, 32'h10120213);
    put(36, 32'h3E80006F);
    put(472, 32'h00108393); put(476, 32'h30200073);
    put(480, 32'h00208393); put(484, 32'h30200073);
    put(488, 32'h00308393); put(492, 32'h30200073);

    step(2);
    check("rst_pc", dut.pc_q, 64'd0);
    check("rst_x1", dut.rf[1], 64'd0);
    check("rst_mepc", dut.mepc, 64'd0);
    check("rst_mcause", dut.mcause, 64'd0);
    rstn = 1'b0;

    step(1);
    check("addi_x1", dut.rf[1], 64'd2);
    check("addi_pc", dut.pc_q, 64'd4);
    step(1);
    check("ill_pc", dut.pc_q, 64'd480);
    check("ill_mcause", dut.mcause, 64'd2);
    check("ill_mepc", dut.mepc, 64'd8);
    step(3);
    check("ill_x7", dut.rf[7], 64'd4);
    check("ill_x3", dut.rf[3], 64'd257);
    check("ill_pc_resume", dut.pc_q, 64'd12);

    step(3);
    check("lsf_pc", dut.pc_q, 64'd472);
    check("lsf_mcause", dut.mcause, 64'd5);
    check("lsf_mepc", dut.mepc, 64'd24);
    check("lsf_x10", dut.rf[10], 64'd0);
    step(1);
    check("lsf_x7", dut.rf[7], 64'd3);
    step(1);
    check("lsf_pc_resume", dut.pc_q, 64'd24);

    step(4);
    check("iaf_pc", dut.pc_q, 64'd488);
    check("iaf_mcause", dut.mcause, 64'd1);
    check("iaf_mepc", dut.mepc, 64'd40);
    check("iaf_x0", dut.rf[0], 64'd0);
    step(2);
    check("iaf_x7", dut.rf[7], 64'd5);
    check("iaf_pc_resume", dut.pc_q, 64'd40);
    step(2);
    check("seq_x3", dut.rf[3], 64'd771);
    check("seq_x4", dut.rf[4], 64'd771);
    check("seq_x7", dut.rf[7], 64'd5);
    check("seq_pc", dut.pc_q, 64'd48);

    // Program B: store/load round trip, LUI, SUB
    rstn = 1'b1;
    step(1);
    check("rst2_pc", dut.pc_q, 64'd0);
    check("rst2_mcause", dut.mcause, 64'd0);
    check("rst2_mepc", dut.mepc, 64'd0);
    check("rst2_rf", rf_nonzero(), 64'd0);
    clear_imem();
    put(0,  32'hFFD00093); put(4,  32'h00103423); put(8, 32'h00803103);
    put(12, 32'h12345237); put(16, 32'h401202B3);
    rstn = 1'b0;
    step(5);
    check("ld_x2", dut.rf[2], 64'hFFFF_FFFF_FFFF_FFFD);
    check("lui_x4", dut.rf[4], 64'h0000_0000_1234_5000);
    check("sub_x5", dut.rf[5], 64'h0000_0000_1234_5003);
    check("sd_byte8", 64'(dut.dmem[8]), 64'hFD);
    check("sd_byte15", 64'(dut.dmem[15]), 64'hFF);

    rstn = 1'b1;
    step(1);
    check("mid_rst_pc", dut.pc_q, 64'd0);
    check("mid_rst_rf", rf_nonzero(), 64'd0);
    check("mid_rst_mem", 64'(dut.dmem[8]), 64'hFD);

    // Program C: BNE/BEQ/JAL and misaligned JALR target
    clear_imem();
    put(0,  32'h00500093); put(4,  32'h00009463); put(8,  32'h00100113);
    put(12, 32'h008001EF); put(16, 32'h00100113); put(20, 32'h00008463);
    put(24, 32'h00200067);
    rstn = 1'b0;
    step(1);
    check("c_x1", dut.rf[1], 64'd5);
    step(1);
    check("bne_pc", dut.pc_q, 64'd12);
    step(1);
    check("jal_pc", dut.pc_q, 64'd20);
    check("jal_link", dut.rf[3], 64'd16);
    step(1);
    check("beq_nt_pc", dut.pc_q, 64'd24);
    step(1);
    check("jalr_mis_pc", dut.pc_q, 64'd488);
    check("jalr_mis_mcause", dut.mcause, 64'd1);
    check("jalr_mis_mepc", dut.mepc, 64'd28);
    check("skip_x2", dut.rf[2], 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
